// File: rtl/reu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : reu_ram_arbiter
// Shares the REU expansion-RAM port between DMA accesses and periodic refresh.
// Rev     : 1.0  initial release
// ============================================================================
module reu_ram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int REF_INTERVAL = 15,
  parameter int REF_MAXPEND  = 4,
  parameter int ACC_CYC      = 2,
  parameter int REF_CYC      = 1
) (
  input  logic              PHI2,
  input  logic              RESET,
  input  logic              DmaReq,
  input  logic              DmaWr,
  input  logic [ADDR_W-1:0] DmaAddr,
  input  logic [7:0]        DmaWData,
  output logic              DmaAck,
  output logic [7:0]        DmaRData,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [7:0]        RamDout,
  input  logic [7:0]        RamDin,
  output logic              RamRD,
  output logic              RamWR,
  output logic              RamRef,
  output logic              Busy,
  output logic              RefOverrun
);

  localparam int c_tmr_w  = $clog2(REF_INTERVAL);
  localparam int c_pend_w = $clog2(REF_MAXPEND + 1);
  localparam int c_cyc_mx = (ACC_CYC > REF_CYC) ? ACC_CYC : REF_CYC;
  localparam int c_cnt_w  = $clog2(c_cyc_mx + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_REFRESH = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [c_tmr_w-1:0]  r_tmr;
  logic [c_pend_w-1:0] r_pend;
  logic                r_ovr;
  logic                r_ack, w_ack_nxt;
  logic [7:0]          r_rdata, w_rdata_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [7:0]          r_dout, w_dout_nxt;
  logic                r_rd, w_rd_nxt;
  logic                r_wr, w_wr_nxt;
  logic                r_ref, w_ref_nxt;
  logic                r_busy;
  logic                r_wrlat, w_wrlat_nxt;
  logic                w_tick, w_full, w_dec;

  assign w_tick = (r_tmr == c_tmr_w'(REF_INTERVAL - 1));
  assign w_full = (r_pend == c_pend_w'(REF_MAXPEND));

  // A tick and a refresh completion on the same edge cancel out, even at saturation.
  always_ff @(negedge PHI2 or posedge RESET) begin
    if (RESET) begin
      r_tmr  <= '0;
      r_pend <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_tmr <= w_tick ? '0 : r_tmr + c_tmr_w'(1);
      if (w_tick && !w_dec) begin
        if (w_full) r_ovr  <= 1'b1;
        else        r_pend <= r_pend + c_pend_w'(1);
      end else if (!w_tick && w_dec) begin
        r_pend <= r_pend - c_pend_w'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_ref_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_rdata_nxt = r_rdata;
    w_wrlat_nxt = r_wrlat;
    w_dec       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // DmaAck high marks the turnaround cycle; the held request is not re-taken.
        if (w_full) begin
          w_state_nxt = S_REFRESH;
          w_cnt_nxt   = '0;
          w_ref_nxt   = 1'b1;
        end else if (DmaReq && !r_ack) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = '0;
          w_addr_nxt  = DmaAddr;
          w_wrlat_nxt = DmaWr;
          if (DmaWr) w_dout_nxt = DmaWData;
          w_rd_nxt    = !DmaWr;
          w_wr_nxt    = DmaWr;
        end else if (r_pend != '0) begin
          w_state_nxt = S_REFRESH;
          w_cnt_nxt   = '0;
          w_ref_nxt   = 1'b1;
        end
      end
      S_ACCESS: begin
        if (r_cnt == c_cnt_w'(ACC_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_ack_nxt   = 1'b1;
          if (!r_wrlat) w_rdata_nxt = RamDin;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
          w_rd_nxt  = !r_wrlat;
          w_wr_nxt  = r_wrlat;
        end
      end
      S_REFRESH: begin
        if (r_cnt == c_cnt_w'(REF_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_dec       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
          w_ref_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge PHI2 or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ref   <= 1'b0;
      r_busy  <= 1'b0;
      r_wrlat <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_rdata <= w_rdata_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_ref   <= w_ref_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_wrlat <= w_wrlat_nxt;
    end
  end

  assign DmaAck     = r_ack;
  assign DmaRData   = r_rdata;
  assign RamAddr    = r_addr;
  assign RamDout    = r_dout;
  assign RamRD      = r_rd;
  assign RamWR      = r_wr;
  assign RamRef     = r_ref;
  assign Busy       = r_busy;
  assign RefOverrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_reu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_reu_ram_arbiter
// Random DMA traffic on two arbiter configurations against a timestamp model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_reu_ram_arbiter;

  localparam int AW = 19;

  int p_int [2] = '{15, 2};
  int p_acc [2] = '{2, 6};
  int p_max [2] = '{4, 4};
  int p_ref [2] = '{1, 1};

  logic PHI2  = 1'b1;
  logic RESET = 1'b1;
  always #5 PHI2 = ~PHI2;

  logic          req [2], wr [2], ack [2], rd [2], wrs [2], rf [2], busy [2], ovr [2];
  logic [AW-1:0] addr [2], raddr [2];
  logic [7:0]    wdata [2], din [2], rdata [2], dout [2];

  reu_ram_arbiter u0 (
    .PHI2(PHI2), .RESET(RESET), .DmaReq(req[0]), .DmaWr(wr[0]), .DmaAddr(addr[0]),
    .DmaWData(wdata[0]), .DmaAck(ack[0]), .DmaRData(rdata[0]), .RamAddr(raddr[0]),
    .RamDout(dout[0]), .RamDin(din[0]), .RamRD(rd[0]), .RamWR(wrs[0]), .RamRef(rf[0]),
    .Busy(busy[0]), .RefOverrun(ovr[0])
  );

  reu_ram_arbiter #(.REF_INTERVAL(2), .ACC_CYC(6)) u1 (
    .PHI2(PHI2), .RESET(RESET), .DmaReq(req[1]), .DmaWr(wr[1]), .DmaAddr(addr[1]),
    .DmaWData(wdata[1]), .DmaAck(ack[1]), .DmaRData(rdata[1]), .RamAddr(raddr[1]),
    .RamDout(dout[1]), .RamDin(din[1]), .RamRD(rd[1]), .RamWR(wrs[1]), .RamRef(rf[1]),
    .Busy(busy[1]), .RefOverrun(ovr[1])
  );

  // Model: edge count since reset, mode (0 idle / 1 access / 2 refresh) and the edge it ends on.
  int            m_cyc [2], m_pend [2], m_mode [2], m_end [2];
  bit            m_wr [2];
  bit            e_ack [2], e_rd [2], e_wr [2], e_ref [2], e_busy [2], e_ovr [2];
  logic [AW-1:0] e_addr [2];
  logic [7:0]    e_dout [2], e_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;
  int density = 0;
  int n_dir   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_pend[i] = 0; m_mode[i] = 0; m_end[i] = 0; m_wr[i] = 0;
      e_ack[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_ref[i] = 0; e_busy[i] = 0; e_ovr[i] = 0;
      e_addr[i] = '0; e_dout[i] = '0; e_rdata[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    int e;
    bit ack_prev, dec, tick, full;
    m_cyc[i]++;
    e        = m_cyc[i];
    ack_prev = e_ack[i];
    full     = (m_pend[i] == p_max[i]);
    dec      = 0;
    e_ack[i] = 0;
    if (m_mode[i] == 1 && e == m_end[i]) begin
      e_ack[i]  = 1;
      if (!m_wr[i]) e_rdata[i] = din[i];
      m_mode[i] = 0;
    end else if (m_mode[i] == 2 && e == m_end[i]) begin
      dec       = 1;
      m_mode[i] = 0;
    end else if (m_mode[i] == 0) begin
      if (full) begin
        m_mode[i] = 2; m_end[i] = e + p_ref[i];
      end else if (req[i] && !ack_prev) begin
        m_mode[i] = 1; m_end[i] = e + p_acc[i];
        m_wr[i]   = wr[i];
        e_addr[i] = addr[i];
        if (wr[i]) e_dout[i] = wdata[i];
      end else if (m_pend[i] > 0) begin
        m_mode[i] = 2; m_end[i] = e + p_ref[i];
      end
    end
    tick = ((e % p_int[i]) == 0);
    if (tick && !dec) begin
      if (full) e_ovr[i] = 1;
      else      m_pend[i]++;
    end else if (!tick && dec) begin
      m_pend[i]--;
    end
    e_rd[i]   = (m_mode[i] == 1) && !m_wr[i];
    e_wr[i]   = (m_mode[i] == 1) && m_wr[i];
    e_ref[i]  = (m_mode[i] == 2);
    e_busy[i] = (m_mode[i] != 0);
  endtask

  always @(negedge PHI2) begin
    if (!RESET) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check_all(input int i);
    check($sformatf("u%0d.DmaAck", i),     32'(ack[i]),   32'(e_ack[i]));
    check($sformatf("u%0d.DmaRData", i),   32'(rdata[i]), 32'(e_rdata[i]));
    check($sformatf("u%0d.RamAddr", i),    32'(raddr[i]), 32'(e_addr[i]));
    check($sformatf("u%0d.RamDout", i),    32'(dout[i]),  32'(e_dout[i]));
    check($sformatf("u%0d.RamRD", i),      32'(rd[i]),    32'(e_rd[i]));
    check($sformatf("u%0d.RamWR", i),      32'(wrs[i]),   32'(e_wr[i]));
    check($sformatf("u%0d.RamRef", i),     32'(rf[i]),    32'(e_ref[i]));
    check($sformatf("u%0d.Busy", i),       32'(busy[i]),  32'(e_busy[i]));
    check($sformatf("u%0d.RefOverrun", i), 32'(ovr[i]),   32'(e_ovr[i]));
    if (i == 0 && e_ack[0] && n_dir == 1)
      check("u0.first_read_data", 32'(rdata[0]), 32'h0000_00A5);
  endtask

  task automatic new_req(input int i);
    req[i] = 1'b1;
    if (i == 0 && n_dir == 0) begin
      wr[0] = 1'b0; addr[0] = 19'h12345; wdata[0] = 8'h00; n_dir = 1;
    end else if (i == 0 && n_dir == 1) begin
      wr[0] = 1'b1; addr[0] = 19'h7FFFF; wdata[0] = 8'h3C; n_dir = 2;
    end else begin
      wr[i] = 1'($urandom); addr[i] = AW'($urandom); wdata[i] = 8'($urandom);
    end
  endtask

  task automatic drive(input int i);
    din[i] = 8'($urandom);
    if (i == 0 && n_dir == 1) din[0] = 8'hA5;
    if (m_mode[i] == 1) begin
      addr[i]  = AW'($urandom);
      wdata[i] = 8'($urandom);
    end
    if (e_ack[i]) begin
      if ($urandom_range(0, 1) == 1) new_req(i);
      else                           req[i] = 1'b0;
    end else if (!req[i] && $urandom_range(1, 100) <= density) begin
      new_req(i);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge PHI2);
      for (int i = 0; i < 2; i++) begin
        check_all(i);
        drive(i);
      end
    end
  endtask

  initial begin
    int  k;
    bit  found;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; wr[i] = 0; addr[i] = '0; wdata[i] = '0; din[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge PHI2);
    for (int i = 0; i < 2; i++) check_all(i);
    RESET = 1'b0;

    density = 0;
    run_cycles(50);
    density = 100;
    run_cycles(200);
    check("u0.no_overrun", 32'(ovr[0]), 32'd0);
    check("u1.overrun_set", 32'(ovr[1]), 32'd1);
    density = 30;
    run_cycles(600);
    check("u1.overrun_sticky", 32'(ovr[1]), 32'd1);

    // Hit reset one cycle into a u0 access.
    density = 80;
    found   = 0;
    k       = 0;
    while (!found && k < 300) begin
      run_cycles(1);
      if (m_mode[0] == 1 && (m_end[0] - m_cyc[0]) == p_acc[0]) found = 1;
      k++;
    end
    check("rst_wait_found", 32'(found), 32'd1);
    #2;
    RESET = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) req[i] = 1'b0;
    #1;
    check("mid_rst.RamRD", 32'(rd[0]), 32'd0);
    check("mid_rst.Busy", 32'(busy[0]), 32'd0);
    check("mid_rst.DmaAck", 32'(ack[0]), 32'd0);
    check("mid_rst.RefOverrun", 32'(ovr[1]), 32'd0);
    @(posedge PHI2);
    for (int i = 0; i < 2; i++) check_all(i);
    RESET = 1'b0;

    density = 0;
    run_cycles(40);
    density = 60;
    run_cycles(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
